// File: rtl/pwm_led_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_led_pkg
// Brief    : Register map, CTRL bit positions and ramp direction for the PWM LED bank.
// Revision : 1.0
// ============================================================================
package pwm_led_pkg;

    localparam logic [5:0] c_ADDR_PRESCALE = 6'd0;
    localparam logic [5:0] c_ADDR_STATUS   = 6'd1;
    localparam logic [5:0] c_ADDR_CH_BASE  = 6'd2;

    localparam int c_CTRL_W       = 3;
    localparam int c_CTRL_EN      = 0;
    localparam int c_CTRL_BREATHE = 1;
    localparam int c_CTRL_INV     = 2;

    typedef enum logic [0:0] {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_dir_t;

    // Each channel occupies a DUTY/CTRL word pair after the two global registers.
    function automatic logic [5:0] duty_addr(input int ch);
        return c_ADDR_CH_BASE + 6'(2 * ch);
    endfunction

    function automatic logic [5:0] ctrl_addr(input int ch);
        return c_ADDR_CH_BASE + 6'(2 * ch + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Brief    : One PWM channel: boundary-latched duty, breathe ramp, compare and output register.
// Revision : 1.0
// ============================================================================
module pwm_channel
    import pwm_led_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_boundary,
    input  logic [PWM_W-1:0]    i_per_cnt,
    input  logic [PWM_W-1:0]    i_duty,
    input  logic [c_CTRL_W-1:0] i_ctrl,
    output logic                o_pwm
);

    localparam logic [PWM_W-1:0] c_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

    logic [PWM_W-1:0] r_active;
    logic [PWM_W-1:0] r_ramp;
    ramp_dir_t        r_dir;
    logic             r_pwm;

    logic [PWM_W-1:0] w_ramp_nxt;
    ramp_dir_t        w_dir_nxt;
    logic [PWM_W-1:0] w_level;
    logic             w_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= '0;
            r_ramp   <= '0;
            r_dir    <= RAMP_UP;
            r_pwm    <= 1'b0;
        end else begin
            if (i_boundary) begin
                r_active <= i_duty;
            end
            // Leaving breathe mode re-arms the ramp so the next entry starts at 0 rising.
            if (!i_ctrl[c_CTRL_BREATHE]) begin
                r_ramp <= '0;
                r_dir  <= RAMP_UP;
            end else if (i_boundary) begin
                r_ramp <= w_ramp_nxt;
                r_dir  <= w_dir_nxt;
            end
            r_pwm <= w_raw ^ i_ctrl[c_CTRL_INV];
        end
    end

    always_comb begin
        w_ramp_nxt = r_ramp;
        w_dir_nxt  = r_dir;
        case (r_dir)
            RAMP_UP: begin
                if (r_ramp < i_duty) begin
                    w_ramp_nxt = r_ramp + c_ONE;
                end else begin
                    w_dir_nxt = RAMP_DOWN;
                    if (r_ramp != '0) begin
                        w_ramp_nxt = r_ramp - c_ONE;
                    end
                end
            end
            RAMP_DOWN: begin
                if (r_ramp != '0) begin
                    w_ramp_nxt = r_ramp - c_ONE;
                end else begin
                    w_dir_nxt = RAMP_UP;
                    if (i_duty != '0) begin
                        w_ramp_nxt = c_ONE;
                    end
                end
            end
            default: begin
                w_dir_nxt  = RAMP_UP;
                w_ramp_nxt = '0;
            end
        endcase
    end

    assign w_level = i_ctrl[c_CTRL_BREATHE] ? r_ramp : r_active;
    assign w_raw   = i_ctrl[c_CTRL_EN] && (i_per_cnt < w_level);
    assign o_pwm   = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_led_bank.sv
`default_nettype none
// ============================================================================
// Module   : pwm_led_bank
// Brief    : Multi-channel LED PWM bank with prescaler, shared period counter and register file.
// Revision : 1.0
// ============================================================================
module pwm_led_bank
    import pwm_led_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PWM_W  = 8,
    parameter int PRE_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [5:0]        wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [5:0]        rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] pwm_out
);

    // The period counter stops one short of all-ones so a full-scale duty stays high.
    localparam logic [PWM_W-1:0] c_PER_MAX = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [PRE_W-1:0]    r_prescale;
    logic [PWM_W-1:0]    r_duty [NUM_CH];
    logic [c_CTRL_W-1:0] r_ctrl [NUM_CH];
    logic                r_status;
    logic [31:0]         r_rd_data;
    logic                r_rd_valid;
    logic [PRE_W-1:0]    r_pre_cnt;
    logic [PWM_W-1:0]    r_per_cnt;

    logic                w_tick;
    logic                w_boundary;
    logic                w_wr_prescale;
    logic                w_rd_status;
    logic [31:0]         w_rd_word;
    logic [NUM_CH-1:0]   w_pwm;
    logic                w_unused;

    assign w_tick        = (r_pre_cnt == r_prescale);
    assign w_boundary    = w_tick && (r_per_cnt == c_PER_MAX);
    assign w_wr_prescale = wr_en && (wr_addr == c_ADDR_PRESCALE);
    assign w_rd_status   = rd_en && (rd_addr == c_ADDR_STATUS);
    assign w_unused      = ^wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= '0;
                r_ctrl[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_addr == c_ADDR_PRESCALE) begin
                r_prescale <= wr_data[PRE_W-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == duty_addr(i)) begin
                    r_duty[i] <= wr_data[PWM_W-1:0];
                end
                if (wr_addr == ctrl_addr(i)) begin
                    r_ctrl[i] <= wr_data[c_CTRL_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_per_cnt <= '0;
        end else begin
            if (w_wr_prescale || w_tick) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
            if (w_tick) begin
                r_per_cnt <= (r_per_cnt == c_PER_MAX) ? '0 : r_per_cnt + PWM_W'(1);
            end
        end
    end

    // A boundary in the same cycle as a STATUS read wins, so the flag is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= 1'b0;
        end else if (w_boundary) begin
            r_status <= 1'b1;
        end else if (w_rd_status) begin
            r_status <= 1'b0;
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (rd_addr == c_ADDR_PRESCALE) begin
            w_rd_word[PRE_W-1:0] = r_prescale;
        end else if (rd_addr == c_ADDR_STATUS) begin
            w_rd_word[0] = r_status | w_boundary;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_addr == duty_addr(i)) begin
                    w_rd_word[PWM_W-1:0] = r_duty[i];
                end
                if (rd_addr == ctrl_addr(i)) begin
                    w_rd_word[c_CTRL_W-1:0] = r_ctrl[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            pwm_channel #(
                .PWM_W (PWM_W)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .i_boundary (w_boundary),
                .i_per_cnt  (r_per_cnt),
                .i_duty     (r_duty[g]),
                .i_ctrl     (r_ctrl[g]),
                .o_pwm      (w_pwm[g])
            );
        end
    endgenerate

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign pwm_out  = w_pwm;

endmodule
`default_nettype wire

// File: doc/pwm_led_bank.md
PWM_LED_BANK -- requirements
Module: pwm_led_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of PWM channels (1..16).
REQ-002 SHALL have parameter PWM_W, default 8, duty/counter width in bits (4..16).
REQ-003 SHALL have parameter PRE_W, default 16, prescaler width in bits.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  register write strobe, one write per cycle.
REQ-007 SHALL have port wr_addr  input  6  word address of write.
REQ-008 SHALL have port wr_data  input  32  write data; unused upper bits ignored.
REQ-009 SHALL have port rd_en  input  1  register read strobe.
REQ-010 SHALL have port rd_addr  input  6  word address of read.
REQ-011 SHALL have port rd_data  output  32  read data, zero-extended.
REQ-012 SHALL have port rd_valid  output  1  high exactly one cycle after rd_en.
REQ-013 SHALL have port pwm_out  output  NUM_CH  per-channel PWM output driving LED/RGB pins.

Function
REQ-014 SHALL map registers: 0 PRESCALE (PRE_W bits), 1 STATUS (read-only, bit0 = period-boundary flag, sticky, clear-on-read), 2+2*ch DUTY[ch] (PWM_W bits), 3+2*ch CTRL[ch] (bit0 enable, bit1 breathe mode, bit2 invert).
REQ-015 SHALL ignore writes to STATUS and to addresses >= 2+2*NUM_CH; reads of those unmapped addresses SHALL return 0.
REQ-016 SHALL return register contents as written (DUTY/CTRL/PRESCALE shadow values) on rd_data one cycle after rd_en, with rd_valid high for that cycle.
REQ-017 SHALL run prescaler counter 0..PRESCALE, asserting tick for one cycle when count equals PRESCALE, then wrapping to 0; PRESCALE=0 gives tick every cycle.
REQ-018 SHALL reset prescaler counter to 0 in the cycle after any PRESCALE write.
REQ-019 SHALL run a shared period counter 0..2^PWM_W-2, advancing on tick, wrapping to 0; wrap tick is the period boundary.
REQ-020 SHALL latch each channel's DUTY shadow into its active duty only at a period boundary; a DUTY write coinciding with the boundary tick takes effect at the following boundary.
REQ-021 SHALL drive channel raw output = (period counter < active duty): duty 0 -> constant low, duty 2^PWM_W-1 -> constant high.
REQ-022 SHALL in breathe mode replace active duty with a ramp level: +1 per period up to DUTY shadow, then -1 per period down to 0, repeating; ramp starts at 0 rising when breathe is set.
REQ-023 SHALL, with breathe set and DUTY shadow 0, hold ramp level at 0.
REQ-024 SHALL force raw output low when enable=0; pwm_out = raw XOR invert (disabled+invert -> high).
REQ-025 SHALL register pwm_out (one cycle from counter state to pin, glitch-free).
REQ-026 SHALL set STATUS bit0 on each period boundary; a read coinciding with a boundary returns 1 and the bit remains set.
REQ-027 SHALL give simultaneous write and read of the same address the old value on rd_data.

Reset
REQ-028 SHALL, while reset high, clear PRESCALE, all DUTY, CTRL, active duty, ramp state, counters, STATUS, rd_data, rd_valid and pwm_out to 0.
REQ-029 SHALL, on reset asserted mid-period, drive pwm_out low asynchronously and restart the period counter at 0 after release.

Structure
REQ-030 SHALL place address offsets, CTRL bit positions and ramp-direction enum in shared package pwm_led_pkg.
REQ-031 SHALL implement per-channel duty latch, ramp and compare in sub-module pwm_channel, instantiated NUM_CH times; prescaler, period counter and register file stay in pwm_led_bank.

Verification
REQ-032 SHALL cover: PRESCALE=0, DUTY[0]=64, CTRL[0]=1 -> pwm_out[0] high 64 of every 255 cycles.
REQ-033 SHALL cover: DUTY[1]=0 then 255 with enable -> constant low then, from next boundary, constant high; invert set -> inverse.
REQ-034 SHALL cover: DUTY[0] changed 64->128 mid-period -> current period keeps 64-cycle high, next period 128.
REQ-035 SHALL cover: CTRL[2]=3, DUTY[2]=3, PRESCALE=0 -> successive period high-times 0,1,2,3,2,1,0,1.
REQ-036 SHALL cover: read addr 2+2*NUM_CH -> rd_data 0, rd_valid one cycle; STATUS read after boundary -> 1, next read -> 0.
REQ-037 SHALL cover: reset pulsed mid-period with pwm_out high -> pwm_out low immediately, all registers read 0 after release.
